// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: two-CPU round-robin arbiter for one shared memory port; optional grant lock under CPU_BUS_ARBITER_LOCK_EN
module cpu_bus_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0] state;
    logic [1:0] pick;
    logic [2:0] cnt;
    logic       last;
    logic       we_q;
    logic       issue;
    logic       sel;
`ifdef CPU_BUS_ARBITER_LOCK_EN
    logic       lock_v;
    logic       lock_id;
`else
    logic       unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    assign issue     = state == ISSUE;
    assign sel       = grant[1];
    assign mem_en    = issue;
    assign mem_we    = issue & (sel ? we1 : we0);
    assign mem_addr  = issue ? (sel ? addr1 : addr0) : '0;
    assign mem_wdata = issue ? (sel ? wdata1 : wdata0) : '0;
    assign ack0      = (state == ACK) & grant[0];
    assign ack1      = (state == ACK) & grant[1];

    // IDLE winner: a held lock beats round-robin, a tie goes to the one not granted last
    always_comb begin
        pick = (req0 && req1) ? (last ? 2'b01 : 2'b10) : {req1, req0};
`ifdef CPU_BUS_ARBITER_LOCK_EN
        if (lock_v && (lock_id ? req1 : req0)) pick = lock_id ? 2'b10 : 2'b01;
`endif
    end

    // transaction FSM: grant, one issue cycle, MEM_LAT wait cycles, one ack cycle
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
            last  <= 1'b1;
            we_q  <= 1'b0;
            rdata <= '0;
`ifdef CPU_BUS_ARBITER_LOCK_EN
            lock_v  <= 1'b0;
            lock_id <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|pick) begin
                    grant <= pick;
                    state <= ISSUE;
`ifdef CPU_BUS_ARBITER_LOCK_EN
                    lock_v <= 1'b0;
`endif
                end
                ISSUE: begin
                    we_q  <= mem_we;
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (cnt == 3'(MEM_LAT - 1)) begin
                    state <= ACK;
                    if (!we_q) rdata <= mem_rdata;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                ACK: begin
                    state <= IDLE;
                    grant <= '0;
                    cnt   <= '0;
`ifdef CPU_BUS_ARBITER_LOCK_EN
                    if (sel ? lock1 : lock0) begin
                        lock_v  <= 1'b1;
                        lock_id <= sel;
                    end else begin
                        last <= sel;
                    end
`else
                    last <= sel;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: transaction-level model check of two arbiter instances (MEM_LAT 1 and 3) plus directed literal checks
module tb_cpu_bus_arbiter;
    logic clk = 1'b0;
    logic rst_p = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [6:0] addr0 = 0, addr1 = 0;
    logic [3:0] wdata0 = 0, wdata1 = 0;
    logic [1:0] ack0_o, ack1_o, mem_en_o, mem_we_o;
    logic [1:0][1:0] grant_o;
    logic [1:0][3:0] rdata_o, mem_wdata_o, mrdi;
    logic [1:0][6:0] mem_addr_o;
    int tests = 0, fails = 0;
    bit started = 0;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.ADDR_W(7), .DATA_W(4), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst_p(rst_p), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0), .lock1(lock1),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]), .rdata(rdata_o[0]), .grant(grant_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mrdi[0]));

    cpu_bus_arbiter #(.ADDR_W(7), .DATA_W(4), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst_p(rst_p), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0), .lock1(lock1),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]), .rdata(rdata_o[1]), .grant(grant_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mrdi[1]));

    function automatic int lat(input int d);
        return d ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // memory per instance: data is valid exactly MEM_LAT cycles after the mem_en cycle, inverted otherwise
    logic [3:0] mem [2][128];
    int ncyc = 0;
    int tis [2] = '{-100, -100};
    logic [6:0] ra [2] = '{7'h0, 7'h0};
    assign mrdi[0] = (ncyc == tis[0] + 2) ? mem[0][ra[0]] : ~mem[0][ra[0]];
    assign mrdi[1] = (ncyc == tis[1] + 4) ? mem[1][ra[1]] : ~mem[1][ra[1]];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (mem_en_o[d]) begin
                tis[d] = ncyc;
                ra[d] = mem_addr_o[d];
                if (mem_we_o[d]) mem[d][mem_addr_o[d]] = mem_wdata_o[d];
            end
        ncyc++;
    end

    // transaction model: k counts cycles since the grant (1 = issue, 2+lat = ack)
    bit busy [2], rw [2], lv [2];
    int k [2], own [2], lastm [2], lid [2];
    logic [3:0] mrd [2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_p) begin
                busy[d] = 0; k[d] = 0; lastm[d] = 1; mrd[d] = 0; lv[d] = 0; own[d] = 0;
            end else if (busy[d]) begin
                if (k[d] == 1) rw[d] = own[d] ? we1 : we0;
                if (k[d] == 1 + lat(d) && !rw[d]) mrd[d] = mrdi[d];
                if (k[d] == 2 + lat(d)) begin
                    busy[d] = 0;
`ifdef CPU_BUS_ARBITER_LOCK_EN
                    if (own[d] ? lock1 : lock0) begin lv[d] = 1; lid[d] = own[d]; end
                    else lastm[d] = own[d];
`else
                    lastm[d] = own[d];
`endif
                end else k[d]++;
            end else if (req0 || req1) begin
                if (lv[d] && (lid[d] ? req1 : req0)) own[d] = lid[d];
                else if (req0 && req1) own[d] = 1 - lastm[d];
                else own[d] = req1 ? 1 : 0;
                busy[d] = 1; k[d] = 1; lv[d] = 0;
            end
        end
    end

    always @(negedge clk) if (started)
        for (int d = 0; d < 2; d++) begin
            chk("grant", d, grant_o[d], busy[d] ? (own[d] ? 2'b10 : 2'b01) : 2'b00);
            chk("ack0", d, ack0_o[d], busy[d] && k[d] == 2 + lat(d) && own[d] == 0);
            chk("ack1", d, ack1_o[d], busy[d] && k[d] == 2 + lat(d) && own[d] == 1);
            chk("mem_en", d, mem_en_o[d], busy[d] && k[d] == 1);
            chk("mem_we", d, mem_we_o[d], busy[d] && k[d] == 1 && (own[d] ? we1 : we0));
            chk("mem_addr", d, mem_addr_o[d], (busy[d] && k[d] == 1) ? (own[d] ? addr1 : addr0) : 7'h0);
            chk("mem_wdata", d, mem_wdata_o[d], (busy[d] && k[d] == 1) ? (own[d] ? wdata1 : wdata0) : 4'h0);
            chk("rdata", d, rdata_o[d], mrd[d]);
        end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int who [$];
    int when [$];
    int exp_lock [4];

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 128; a++) mem[d][a] = 4'(a * 3 + d);
        mem[0][7'h15] = 4'hA;
        mem[1][7'h15] = 4'h6;
        tick;
        started = 1;
        tick;
        rst_p = 0;
        // single read of 0x15 from CPU 0
        req0 = 1; we0 = 0; addr0 = 7'h15;
        @(negedge clk);
        @(negedge clk);
        chk("r22_en", 0, mem_en_o[0], 1);
        chk("r22_addr", 0, mem_addr_o[0], 7'h15);
        @(negedge clk);
        chk("r22_noack", 0, ack0_o[0], 0);
        @(negedge clk);
        chk("r22_ack", 0, ack0_o[0], 1);
        chk("r22_rdata", 0, rdata_o[0], 4'hA);
        tick;
        req0 = 0;
        @(negedge clk);
        chk("r27_noack", 1, ack0_o[1], 0);
        @(negedge clk);
        chk("r27_ack", 1, ack0_o[1], 1);
        chk("r27_rdata", 1, rdata_o[1], 4'h6);
        repeat (3) tick;
        // single write from CPU 1
        req1 = 1; we1 = 1; addr1 = 7'h7F; wdata1 = 4'h5;
        @(negedge clk);
        @(negedge clk);
        chk("r24_en", 0, mem_en_o[0], 1);
        chk("r24_we", 0, mem_we_o[0], 1);
        chk("r24_addr", 0, mem_addr_o[0], 7'h7F);
        chk("r24_wdata", 0, mem_wdata_o[0], 4'h5);
        @(negedge clk);
        chk("r24_en_off", 0, mem_en_o[0], 0);
        @(negedge clk);
        chk("r24_ack", 0, ack1_o[0], 1);
        chk("r24_rdata_kept", 0, rdata_o[0], 4'hA);
        tick;
        req1 = 0; we1 = 0;
        repeat (4) tick;
        chk("r24_mem", 0, mem[0][7'h7F], 4'h5);
        chk("r24_rdata_kept", 1, rdata_o[1], 4'h6);
        // reset in the middle of a read
        req0 = 1; addr0 = 7'h15;
        tick;
        tick;
        rst_p = 1; req1 = 1;
        tick;
        rst_p = 0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("r25_noack", d, ack0_o[d], 0);
            chk("r25_grant0", d, grant_o[d], 2'b00);
            chk("r25_en0", d, mem_en_o[d], 0);
            chk("r25_rdata0", d, rdata_o[d], 4'h0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("r25_tie", d, grant_o[d], 2'b01);
        tick;
        req0 = 0; req1 = 0;
        repeat (10) tick;
        // both requesting continuously
        rst_p = 1;
        tick;
        rst_p = 0; req0 = 1; req1 = 1; addr1 = 7'h20;
        for (int i = 0; i < 60 && who.size() < 4; i++) begin
            @(negedge clk);
            if (ack0_o[0]) begin who.push_back(0); when.push_back(i); end
            if (ack1_o[0]) begin who.push_back(1); when.push_back(i); end
        end
        chk("r23_count", 0, who.size(), 4);
        for (int j = 0; j < who.size(); j++) begin
            chk("r23_order", 0, who[j], j % 2);
            if (j > 0) chk("r23_spacing", 0, when[j] - when[j-1], 4);
        end
        tick;
        req0 = 0; req1 = 0;
        repeat (10) tick;
        // lock held by CPU 0 for two acks, then released
`ifdef CPU_BUS_ARBITER_LOCK_EN
        exp_lock = '{0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 1};
`endif
        who.delete();
        rst_p = 1;
        tick;
        rst_p = 0; req0 = 1; req1 = 1; lock0 = 1;
        for (int i = 0; i < 60 && who.size() < 4; i++) begin
            @(negedge clk);
            if (ack0_o[0]) who.push_back(0);
            if (ack1_o[0]) who.push_back(1);
            if ((ack0_o[0] || ack1_o[0]) && who.size() == 2) begin
                @(posedge clk);
                #1 lock0 = 0;
            end
        end
        chk("r26_count", 0, who.size(), 4);
        for (int j = 0; j < who.size() && j < 4; j++) chk("r26_order", 0, who[j], exp_lock[j]);
        tick;
        req0 = 0; req1 = 0;
        repeat (10) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
